counter_nbit_mod: RTL and testbench

COUNTER_NBIT_MOD -- requirements
Module: counter_nbit_mod

---
 rtl/counter_nbit_mod.sv | 79 +++++++
 tb/tb_counter_nbit_mod.sv | 137 +++++++++++++
 2 files changed

// File: rtl/counter_nbit_mod.sv
// rtl/counter_nbit_mod.sv - up/down modulo counter with load, clear, compare and boundary flags
// Wrap or saturate at 0..MAX_VAL; Cout pulses and Ovf latches whenever an enabled count hits a boundary.
module counter_nbit_mod #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             E,
  input  logic             D,
  input  logic             Load,
  input  logic [WIDTH-1:0] In,
  input  logic             Clr,
  input  logic [WIDTH-1:0] Cmp,
  output logic [WIDTH-1:0] Q,
  output logic             Cout,
  output logic             Match,
  output logic             Ovf
);

  localparam logic [WIDTH-1:0] MAX = MAX_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] q_q, q_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      q_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    q_d    = q_q;
    cout_d = 1'b0;
    ovf_d  = ovf_q;
    if (Clr) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (Load) begin
      q_d   = (In > MAX) ? MAX : In;
      ovf_d = 1'b0;
    end else if (E) begin
      if (!D) begin
        // >= keeps the counter inside range even if state were ever corrupted
        if (q_q >= MAX) begin
          cout_d = 1'b1;
          ovf_d  = 1'b1;
          q_d    = SATURATE ? MAX : '0;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (q_q == '0) begin
          cout_d = 1'b1;
          ovf_d  = 1'b1;
          q_d    = SATURATE ? '0 : MAX;
        end else if (q_q > MAX) begin
          q_d = MAX;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  assign Q     = q_q;
  assign Cout  = cout_q;
  assign Ovf   = ovf_q;
  assign Match = (q_q == Cmp);

endmodule

// File: tb/tb_counter_nbit_mod.sv
// tb/tb_counter_nbit_mod.sv - directed bench for counter_nbit_mod, wrap and saturate instances
// Both instances share inputs; outputs are sampled 1 time unit after each rising edge.
module tb_counter_nbit_mod;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       E, D, Load, Clr;
  logic [7:0] In, Cmp;
  logic [7:0] wq, sq;
  logic       wcout, wmatch, wovf;
  logic       scout, smatch, sovf;

  int total  = 0;
  int passed = 0;

  counter_nbit_mod #(.WIDTH(8), .MAX_VAL(199), .SATURATE(1'b0)) u_wrap (
    .Clk(Clk), .Rst(Rst), .E(E), .D(D), .Load(Load), .In(In), .Clr(Clr), .Cmp(Cmp),
    .Q(wq), .Cout(wcout), .Match(wmatch), .Ovf(wovf)
  );

  counter_nbit_mod #(.WIDTH(8), .MAX_VAL(199), .SATURATE(1'b1)) u_sat (
    .Clk(Clk), .Rst(Rst), .E(E), .D(D), .Load(Load), .In(In), .Clr(Clr), .Cmp(Cmp),
    .Q(sq), .Cout(scout), .Match(smatch), .Ovf(sovf)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_w(input string tag, input int q, input bit c, input bit o);
    chk({tag, " wrap Q"}, 32'(wq), 32'(q));
    chk({tag, " wrap Cout"}, 32'(wcout), 32'(c));
    chk({tag, " wrap Ovf"}, 32'(wovf), 32'(o));
  endtask

  task automatic chk_s(input string tag, input int q, input bit c, input bit o);
    chk({tag, " sat Q"}, 32'(sq), 32'(q));
    chk({tag, " sat Cout"}, 32'(scout), 32'(c));
    chk({tag, " sat Ovf"}, 32'(sovf), 32'(o));
  endtask

  initial begin
    Rst = 1'b1; E = 1'b0; D = 1'b0; Load = 1'b0; Clr = 1'b0; In = 8'd0; Cmp = 8'd5;
    #1;
    chk_w("reset", 0, 0, 0);
    chk_s("reset", 0, 0, 0);
    step();
    Rst = 1'b0;

    // wrap up
    Load = 1'b1; In = 8'd197;
    step(); chk_w("up load", 197, 0, 0);
    Load = 1'b0; E = 1'b1; D = 1'b0;
    step(); chk_w("up1", 198, 0, 0); chk_s("up1", 198, 0, 0);
    step(); chk_w("up2", 199, 0, 0); chk_s("up2", 199, 0, 0);
    step(); chk_w("up3", 0, 1, 1);   chk_s("up3", 199, 1, 1);
    step(); chk_w("up4", 1, 0, 1);   chk_s("up4", 199, 1, 1);

    // wrap down
    E = 1'b0; Load = 1'b1; In = 8'd1;
    step(); chk_w("dn load", 1, 0, 0);
    Load = 1'b0; E = 1'b1; D = 1'b1;
    step(); chk_w("dn1", 0, 0, 0);
    step(); chk_w("dn2", 199, 1, 1); chk_s("dn2", 0, 1, 1);
    step(); chk_w("dn3", 198, 0, 1);

    // saturate
    E = 1'b0; D = 1'b0; Load = 1'b1; In = 8'd198;
    step(); chk_s("sat load", 198, 0, 0);
    Load = 1'b0; E = 1'b1;
    step(); chk_s("sat1", 199, 0, 0);
    step(); chk_s("sat2", 199, 1, 1);
    step(); chk_s("sat3", 199, 1, 1);
    step(); chk_s("sat4", 199, 1, 1);

    // priority and clamp
    Clr = 1'b1; Load = 1'b1; In = 8'd50; E = 1'b1;
    step(); chk_w("clr prio", 0, 0, 0); chk_s("clr prio", 0, 0, 0);
    Clr = 1'b0; Load = 1'b1; In = 8'd250;
    step(); chk_w("clamp", 199, 0, 0);
    Load = 1'b0; E = 1'b0;
    step(); chk_w("hold1", 199, 0, 0);
    step(); step(); chk_w("hold3", 199, 0, 0);

    // direction change takes effect on next edge
    Load = 1'b1; In = 8'd10;
    step();
    Load = 1'b0; E = 1'b1; D = 1'b0;
    step(); chk_w("dir up", 11, 0, 0);
    D = 1'b1;
    step(); chk_w("dir down", 10, 0, 0);

    // async reset clears a pending Cout/Ovf
    E = 1'b0; D = 1'b0; Load = 1'b1; In = 8'd199;
    step();
    Load = 1'b0; E = 1'b1;
    step(); chk_w("pre rst", 0, 1, 1);
    #2 Rst = 1'b1;
    #1 chk_w("rst cout", 0, 0, 0);
    Rst = 1'b0;

    // async reset mid-count from 120
    E = 1'b0; Load = 1'b1; In = 8'd119;
    step();
    Load = 1'b0; E = 1'b1; D = 1'b0;
    step(); chk_w("pre rst2", 120, 0, 0);
    #2 Rst = 1'b1;
    #1 chk_w("async rst", 0, 0, 0);
    Load = 1'b1; In = 8'd77;
    step(); chk_w("rst ignores", 0, 0, 0);
    Rst = 1'b0; Load = 1'b0;
    step(); chk_w("post rst", 1, 0, 0);

    // match
    E = 1'b0; Cmp = 8'd5; Load = 1'b1; In = 8'd3;
    step(); chk("match q3", 32'(wmatch), 0);
    Load = 1'b0; E = 1'b1;
    step(); chk("match q4", 32'(wmatch), 0);
    step(); chk("match q5", 32'(wmatch), 1); chk("match q5 Q", 32'(wq), 5);
    step(); chk("match q6", 32'(wmatch), 0);
    E = 1'b0; Cmp = 8'd6;
    #1 chk("match comb", 32'(wmatch), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
